register_file: RTL and testbench

//  Multi-ported general-purpose register file for the cpu16 datapath.
//  - One synchronous write port and two independent combinational read ports.
//  - Sits between decode (register indices) and the ALU/writeback stage (operands, results).

---
 rtl/register_file_read_port.sv | 21 ++
 rtl/register_file.sv | 68 ++++++
 tb/tb_register_file.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/register_file_read_port.sv
// Combinational read mux for the register file; an index beyond the last
// implemented register reads as zero.
module register_file_read_port #(
  parameter int DataWidth  = 8,
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic [DataWidth-1:0]  regs [NumRegs],
  input  logic [IndexWidth-1:0] readAddr,
  output logic [DataWidth-1:0]  readData
);

  // Compare against every implemented index so unmatched codes fall through to zero.
  always_comb begin
    readData = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (readAddr == IndexWidth'(i)) readData = regs[i];
    end
  end

endmodule

// File: rtl/register_file.sv
// cpu16 general-purpose register file: one synchronous write port, two
// combinational read ports, asynchronous active-low clear.
module register_file #(
  parameter int DataWidth  = 8,
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  writeEn,
  input  logic [IndexWidth-1:0] writeAddr,
  input  logic [DataWidth-1:0]  writeData,
  input  logic [IndexWidth-1:0] readAddr1,
  input  logic [IndexWidth-1:0] readAddr2,
  output logic [DataWidth-1:0]  readData1,
  output logic [DataWidth-1:0]  readData2
);

  if (NumRegs < 2) begin : g_chk_numregs
    $error("register_file: NumRegs must be >= 2");
  end
  if (IndexWidth < $clog2(NumRegs)) begin : g_chk_idxw
    $error("register_file: IndexWidth too small for NumRegs");
  end
  if (DataWidth < 1) begin : g_chk_dataw
    $error("register_file: DataWidth must be >= 1");
  end

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] regs_d [NumRegs];

  // Out-of-range write indices match no register and are dropped.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
      if (writeEn && (writeAddr == IndexWidth'(i))) regs_d[i] = writeData;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= regs_d[i];
    end
  end

  register_file_read_port #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs),
    .IndexWidth(IndexWidth)
  ) u_read_port1 (
    .regs    (regs_q),
    .readAddr(readAddr1),
    .readData(readData1)
  );

  register_file_read_port #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs),
    .IndexWidth(IndexWidth)
  ) u_read_port2 (
    .regs    (regs_q),
    .readAddr(readAddr2),
    .readData(readData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file (8-bit data, 16 registers).
module tb_register_file;

  localparam int DataWidth  = 8;
  localparam int NumRegs    = 16;
  localparam int IndexWidth = 4;

  logic                  clk = 1'b0;
  logic                  rstN;
  logic                  writeEn;
  logic [IndexWidth-1:0] writeAddr;
  logic [DataWidth-1:0]  writeData;
  logic [IndexWidth-1:0] readAddr1;
  logic [IndexWidth-1:0] readAddr2;
  logic [DataWidth-1:0]  readData1;
  logic [DataWidth-1:0]  readData2;

  int tests_run    = 0;
  int tests_failed = 0;

  register_file #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs),
    .IndexWidth(IndexWidth)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .writeEn  (writeEn),
    .writeAddr(writeAddr),
    .writeData(writeData),
    .readAddr1(readAddr1),
    .readAddr2(readAddr2),
    .readData1(readData1),
    .readData2(readData2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DataWidth-1:0] obs,
                          input logic [DataWidth-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [IndexWidth-1:0] addr, input logic [DataWidth-1:0] data);
    @(negedge clk);
    writeEn   = 1'b1;
    writeAddr = addr;
    writeData = data;
    @(negedge clk);
    writeEn   = 1'b0;
  endtask

  initial begin
    rstN      = 1'b0;
    writeEn   = 1'b0;
    writeAddr = '0;
    writeData = '0;
    readAddr1 = 4'd0;
    readAddr2 = 4'd15;

    // 1: reset
    #12;
    check_eq("rst_hold_rd1", readData1, 8'h00);
    check_eq("rst_hold_rd2", readData2, 8'h00);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check_eq("rst_rel_rd1_r0", readData1, 8'h00);
    check_eq("rst_rel_rd2_r15", readData2, 8'h00);

    // 2 and 3: write ports 0 / 15, read both simultaneously
    write_reg(4'd0, 8'hAA);
    readAddr1 = 4'd0;
    #1;
    check_eq("wr_r0_rd1", readData1, 8'hAA);
    write_reg(4'd15, 8'h55);
    readAddr2 = 4'd15;
    #1;
    check_eq("wr_r15_rd2", readData2, 8'h55);
    check_eq("dual_rd1_r0", readData1, 8'hAA);
    check_eq("dual_rd2_r15", readData2, 8'h55);
    readAddr1 = 4'd15;
    readAddr2 = 4'd0;
    #1;
    check_eq("swap_rd1_r15", readData1, 8'h55);
    check_eq("swap_rd2_r0", readData2, 8'hAA);
    readAddr2 = 4'd15;
    #1;
    check_eq("same_idx_rd1", readData1, 8'h55);
    check_eq("same_idx_rd2", readData2, 8'h55);

    // 4: read-during-write, no bypass
    @(negedge clk);
    writeEn   = 1'b1;
    writeAddr = 4'd7;
    writeData = 8'h33;
    readAddr1 = 4'd7;
    #1;
    check_eq("rdw_before_edge", readData1, 8'h00);
    @(posedge clk);
    #1;
    check_eq("rdw_after_edge", readData1, 8'h33);
    @(negedge clk);
    writeEn = 1'b0;
    #1;
    check_eq("rdw_after_wen_drop", readData1, 8'h33);

    // 5: writeEn low leaves registers untouched
    writeAddr = 4'd0;
    writeData = 8'hFF;
    readAddr1 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("wen_low_r0", readData1, 8'hAA);
    check_eq("wen_low_r15", readData2, 8'h55);

    // Address change without a clock edge
    readAddr1 = 4'd7;
    #1;
    check_eq("addr_follow_r7", readData1, 8'h33);

    // 6: async reset between edges
    write_reg(4'd3, 8'h12);
    readAddr1 = 4'd3;
    #1;
    check_eq("wr_r3", readData1, 8'h12);
    #1;
    rstN = 1'b0;
    #1;
    check_eq("async_rst_r3", readData1, 8'h00);
    check_eq("async_rst_r15", readData2, 8'h00);

    // Writes while reset is held are ignored
    writeEn   = 1'b1;
    writeAddr = 4'd5;
    writeData = 8'h77;
    readAddr1 = 4'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    writeEn = 1'b0;
    rstN    = 1'b1;
    #1;
    check_eq("wr_in_rst_r5", readData1, 8'h00);
    readAddr1 = 4'd0;
    #1;
    check_eq("post_rst_r0", readData1, 8'h00);

    // Post-reset write still works
    write_reg(4'd9, 8'hC3);
    readAddr2 = 4'd9;
    #1;
    check_eq("post_rst_wr_r9", readData2, 8'hC3);
    check_eq("post_rst_r0_clean", readData1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
